// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped BTB with 2-bit saturating counters, 0-cycle lookup, execute-stage training.
// Optional same-cycle train->lookup forwarding is enabled by defining BTB_BYPASS_EN.
module btb_entry #(
  parameter int               ENT_W   = 8,
  parameter logic [ENT_W-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_we,
  input  logic [ENT_W-1:0] i_d,
  output logic [ENT_W-1:0] o_q
);
  logic [ENT_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset)   r_q <= RST_VAL;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module btb_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid_fetch,
  input  logic        i_valid_rf_read,
  input  logic        i_valid_execute,
  input  logic [15:0] i_current_pc,
  input  logic        i_is_pc_jump,
  input  logic        i_jump,
  input  logic [15:0] i_target_pc,
  output logic        o_prediction,
  output logic [15:0] o_prediction_pc
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 16 - 1 - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [15:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  localparam int               ENT_W   = $bits(entry_t);
  localparam logic [ENT_W-1:0] RST_ENT = {1'b0, {TAG_W{1'b0}}, 16'h0000, 2'b01};

  logic [15:0] r_pc_rf, r_pc_ex;
  logic        r_jmp_ex;

  logic [ENTRIES-1:0][ENT_W-1:0] w_tab;
  logic [IDX_W-1:0] w_tr_idx, w_lk_idx;
  logic [TAG_W-1:0] w_tr_tag, w_lk_tag;
  entry_t           w_tr_ent, w_upd, w_lk_ent;
  logic             w_train, w_tr_hit, w_we, w_lk_hit;
  logic             w_unused_bits;

  // Fetch PC follows the instruction to execute so training indexes the entry it was looked up from.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc_rf  <= 16'h0000;
      r_pc_ex  <= 16'h0000;
      r_jmp_ex <= 1'b0;
    end else begin
      if (i_valid_fetch) r_pc_rf <= i_current_pc;
      if (i_valid_rf_read) begin
        r_pc_ex  <= r_pc_rf;
        r_jmp_ex <= i_is_pc_jump;
      end
    end
  end

  assign w_tr_idx = r_pc_ex[IDX_W:1];
  assign w_tr_tag = r_pc_ex[15:IDX_W+1];
  assign w_tr_ent = entry_t'(w_tab[w_tr_idx]);
  assign w_tr_hit = w_tr_ent.valid && (w_tr_ent.tag == w_tr_tag);
  assign w_train  = i_valid_execute && r_jmp_ex && !i_reset;

  always_comb begin
    w_upd = w_tr_ent;
    w_we  = 1'b0;
    if (w_train) begin
      if (w_tr_hit) begin
        w_we = 1'b1;
        if (i_jump) begin
          w_upd.ctr    = (w_tr_ent.ctr == 2'b11) ? 2'b11 : w_tr_ent.ctr + 2'd1;
          w_upd.target = i_target_pc;
        end else begin
          w_upd.ctr    = (w_tr_ent.ctr == 2'b00) ? 2'b00 : w_tr_ent.ctr - 2'd1;
        end
      end else if (i_jump) begin
        // Only taken branches allocate; a not-taken miss leaves the slot alone.
        w_we         = 1'b1;
        w_upd.valid  = 1'b1;
        w_upd.tag    = w_tr_tag;
        w_upd.target = i_target_pc;
        w_upd.ctr    = 2'b10;
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    btb_entry #(.ENT_W(ENT_W), .RST_VAL(RST_ENT)) u_ent (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_we    (w_we && (w_tr_idx == IDX_W'(g))),
      .i_d     (w_upd),
      .o_q     (w_tab[g])
    );
  end

  assign w_lk_idx = i_current_pc[IDX_W:1];
  assign w_lk_tag = i_current_pc[15:IDX_W+1];

  always_comb begin
    w_lk_ent = entry_t'(w_tab[w_lk_idx]);
`ifdef BTB_BYPASS_EN
    if (w_we && (w_tr_idx == w_lk_idx)) w_lk_ent = w_upd;
`endif
  end

  assign w_lk_hit        = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag);
  assign o_prediction    = w_lk_hit && w_lk_ent.ctr[1];
  assign o_prediction_pc = o_prediction ? w_lk_ent.target : i_current_pc + 16'd2;

  assign w_unused_bits = ^{i_current_pc[0], r_pc_ex[0]};
endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: per-scenario tasks drive step tables; expected lookups go through a scoreboard queue.
module tb_btb_predictor;
  logic        clk, reset;
  logic        valid_fetch, valid_rf_read, valid_execute;
  logic [15:0] current_pc, target_pc;
  logic        is_pc_jump, jump;
  logic        prediction;
  logic [15:0] prediction_pc;

  btb_predictor #(.ENTRIES(16)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_valid_fetch   (valid_fetch),
    .i_valid_rf_read (valid_rf_read),
    .i_valid_execute (valid_execute),
    .i_current_pc    (current_pc),
    .i_is_pc_jump    (is_pc_jump),
    .i_jump          (jump),
    .i_target_pc     (target_pc),
    .o_prediction    (prediction),
    .o_prediction_pc (prediction_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] pc;
    logic        vf, vr, ve, isj, jmp;
    logic [15:0] tpc;
    logic        chk, ep;
    logic [15:0] epc;
  } step_t;

  typedef struct {
    logic        pred;
    logic [15:0] pc;
  } exp_t;

  step_t st[$];
  exp_t  sb[$];
  exp_t  e;
  int    n_chk = 0;
  int    n_err = 0;

  function automatic step_t lk(input logic [15:0] pc, input logic ep, input logic [15:0] epc);
    return '{1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, ep, epc};
  endfunction

  function automatic step_t rst_step();
    return '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
  endfunction

  // Fetch, rf_read, execute for one branch; lookup during the execute cycle is unchecked.
  function automatic void push_train(input logic [15:0] p, input logic j, input logic [15:0] t);
    st.push_back('{1'b0, p, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000});
    st.push_back('{1'b0, p, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000});
    st.push_back('{1'b0, p, 1'b0, 1'b0, 1'b1, 1'b0, j,    t,        1'b0, 1'b0, 16'h0000});
  endfunction

  task automatic apply(input step_t s);
    @(negedge clk);
    reset         = s.rst;
    current_pc    = s.pc;
    valid_fetch   = s.vf;
    valid_rf_read = s.vr;
    valid_execute = s.ve;
    is_pc_jump    = s.isj;
    jump          = s.jmp;
    target_pc     = s.tpc;
  endtask

  task automatic test_reset();
    st.delete();
    st.push_back(rst_step());
    st.push_back(rst_step());
    st.push_back(lk(16'h0040, 1'b0, 16'h0042));
    st.push_back(lk(16'hFFFE, 1'b0, 16'h0000));
    st.push_back(lk(16'h1234, 1'b0, 16'h1236));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) sb.push_back('{st[i].ep, st[i].epc});
      #1;
      if (st[i].chk) begin
        e = sb.pop_front(); n_chk++;
        if ({prediction, prediction_pc} !== {e.pred, e.pc}) begin
          n_err++;
          $display("FAIL reset step %0d: got %b/%h expected %b/%h", i, prediction, prediction_pc, e.pred, e.pc);
        end
      end
    end
  endtask

  task automatic test_allocate();
    st.delete();
    push_train(16'h0040, 1'b1, 16'h0100);
    st.push_back(lk(16'h0040, 1'b1, 16'h0100));
    st.push_back(lk(16'h0050, 1'b0, 16'h0052));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) sb.push_back('{st[i].ep, st[i].epc});
      #1;
      if (st[i].chk) begin
        e = sb.pop_front(); n_chk++;
        if ({prediction, prediction_pc} !== {e.pred, e.pc}) begin
          n_err++;
          $display("FAIL allocate step %0d: got %b/%h expected %b/%h", i, prediction, prediction_pc, e.pred, e.pc);
        end
      end
    end
  endtask

  task automatic test_counter();
    st.delete();
    push_train(16'h0040, 1'b0, 16'h0000); st.push_back(lk(16'h0040, 1'b0, 16'h0042)); // 01
    push_train(16'h0040, 1'b0, 16'h0000); st.push_back(lk(16'h0040, 1'b0, 16'h0042)); // 00
    push_train(16'h0040, 1'b0, 16'h0000); st.push_back(lk(16'h0040, 1'b0, 16'h0042)); // 00
    push_train(16'h0040, 1'b1, 16'h0100); st.push_back(lk(16'h0040, 1'b0, 16'h0042)); // 01
    push_train(16'h0040, 1'b1, 16'h0100); st.push_back(lk(16'h0040, 1'b1, 16'h0100)); // 10
    push_train(16'h0040, 1'b1, 16'h0180); st.push_back(lk(16'h0040, 1'b1, 16'h0180)); // 11
    push_train(16'h0040, 1'b1, 16'h0180); st.push_back(lk(16'h0040, 1'b1, 16'h0180)); // 11
    push_train(16'h0040, 1'b0, 16'h0000); st.push_back(lk(16'h0040, 1'b1, 16'h0180)); // 10
    push_train(16'h0040, 1'b0, 16'h0000); st.push_back(lk(16'h0040, 1'b0, 16'h0042)); // 01
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) sb.push_back('{st[i].ep, st[i].epc});
      #1;
      if (st[i].chk) begin
        e = sb.pop_front(); n_chk++;
        if ({prediction, prediction_pc} !== {e.pred, e.pc}) begin
          n_err++;
          $display("FAIL counter step %0d: got %b/%h expected %b/%h", i, prediction, prediction_pc, e.pred, e.pc);
        end
      end
    end
  endtask

  task automatic test_alias();
    st.delete();
    st.push_back(rst_step());
    push_train(16'h0040, 1'b1, 16'h0100);
    st.push_back(lk(16'h0060, 1'b0, 16'h0062));
    st.push_back(lk(16'h0040, 1'b1, 16'h0100));
    push_train(16'h0060, 1'b1, 16'h0200);
    st.push_back(lk(16'h0060, 1'b1, 16'h0200));
    st.push_back(lk(16'h0040, 1'b0, 16'h0042));
    push_train(16'h0080, 1'b0, 16'h0000);
    st.push_back(lk(16'h0080, 1'b0, 16'h0082));
    st.push_back(lk(16'h0060, 1'b1, 16'h0200));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) sb.push_back('{st[i].ep, st[i].epc});
      #1;
      if (st[i].chk) begin
        e = sb.pop_front(); n_chk++;
        if ({prediction, prediction_pc} !== {e.pred, e.pc}) begin
          n_err++;
          $display("FAIL alias step %0d: got %b/%h expected %b/%h", i, prediction, prediction_pc, e.pred, e.pc);
        end
      end
    end
  endtask

  task automatic test_no_train();
    st.delete();
    // jmp_ex=1 but valid_execute=0: a not-taken outcome must not decrement
    st.push_back('{1'b0, 16'h0060, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000});
    st.push_back('{1'b0, 16'h0060, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000});
    st.push_back('{1'b0, 16'h0060, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000});
    st.push_back('{1'b0, 16'h0060, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000});
    st.push_back(lk(16'h0060, 1'b1, 16'h0200));
    // jmp_ex=0 with valid_execute=1, jump=1: no target change, no allocate
    st.push_back('{1'b0, 16'h0060, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000});
    st.push_back('{1'b0, 16'h0060, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000});
    st.push_back('{1'b0, 16'h0060, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000});
    st.push_back(lk(16'h0060, 1'b1, 16'h0200));
    st.push_back(lk(16'h0040, 1'b0, 16'h0042));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) sb.push_back('{st[i].ep, st[i].epc});
      #1;
      if (st[i].chk) begin
        e = sb.pop_front(); n_chk++;
        if ({prediction, prediction_pc} !== {e.pred, e.pc}) begin
          n_err++;
          $display("FAIL no_train step %0d: got %b/%h expected %b/%h", i, prediction, prediction_pc, e.pred, e.pc);
        end
      end
    end
  endtask

  task automatic test_reset_mid_train();
    st.delete();
    st.push_back(rst_step());
    st.push_back(lk(16'h0060, 1'b0, 16'h0062));
    st.push_back('{1'b0, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000});
    st.push_back('{1'b0, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000});
    st.push_back('{1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000});
    // tracking regs were cleared, so a lingering valid_execute must not train pc 0
    st.push_back('{1'b0, 16'h0040, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0042});
    st.push_back(lk(16'h0040, 1'b0, 16'h0042));
    st.push_back(lk(16'h0000, 1'b0, 16'h0002));
    st.push_back(lk(16'hFFFE, 1'b0, 16'h0000));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) sb.push_back('{st[i].ep, st[i].epc});
      #1;
      if (st[i].chk) begin
        e = sb.pop_front(); n_chk++;
        if ({prediction, prediction_pc} !== {e.pred, e.pc}) begin
          n_err++;
          $display("FAIL reset_mid_train step %0d: got %b/%h expected %b/%h", i, prediction, prediction_pc, e.pred, e.pc);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    st.delete();
    st.push_back(rst_step());
    st.push_back('{1'b0, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000});
    st.push_back('{1'b0, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000});
`ifdef BTB_BYPASS_EN
    st.push_back('{1'b0, 16'h0040, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0100});
`else
    st.push_back('{1'b0, 16'h0040, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0042});
`endif
    st.push_back(lk(16'h0040, 1'b1, 16'h0100));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) sb.push_back('{st[i].ep, st[i].epc});
      #1;
      if (st[i].chk) begin
        e = sb.pop_front(); n_chk++;
        if ({prediction, prediction_pc} !== {e.pred, e.pc}) begin
          n_err++;
          $display("FAIL same_cycle step %0d: got %b/%h expected %b/%h", i, prediction, prediction_pc, e.pred, e.pc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    st.delete();
    // A=0x0044 and B=0x0048 overlap in the pipe and train on consecutive cycles
    st.push_back('{1'b0, 16'h0044, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000});
    st.push_back('{1'b0, 16'h0048, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000});
    st.push_back('{1'b0, 16'h0050, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0400, 1'b0, 1'b0, 16'h0000});
    st.push_back('{1'b0, 16'h0044, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0800, 1'b1, 1'b1, 16'h0400});
    st.push_back(lk(16'h0048, 1'b1, 16'h0800));
    st.push_back(lk(16'h0044, 1'b1, 16'h0400));
    st.push_back(lk(16'h0040, 1'b1, 16'h0100));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) sb.push_back('{st[i].ep, st[i].epc});
      #1;
      if (st[i].chk) begin
        e = sb.pop_front(); n_chk++;
        if ({prediction, prediction_pc} !== {e.pred, e.pc}) begin
          n_err++;
          $display("FAIL back_to_back step %0d: got %b/%h expected %b/%h", i, prediction, prediction_pc, e.pred, e.pc);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; current_pc = 16'h0000; target_pc = 16'h0000;
    valid_fetch = 1'b0; valid_rf_read = 1'b0; valid_execute = 1'b0;
    is_pc_jump = 1'b0; jump = 1'b0;
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_no_train();
    test_reset_mid_train();
    test_same_cycle();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
